spell_dbg_host: RTL and testbench
=================================

Name: spell_dbg_host

Overview:
- Host-side initiator for the spell core's serial debug port; the driving end of the run/step/load/dump/shift interface.
- Accepts byte-level commands (load register, dump register, run, single-step, wait for stop) on a valid/ready interface.
- Serialises each command into the exact pin sequence the core's 8-bit debug shift register expects and returns dump results as bytes.
- Sits in the same clock domain as the core: a test harness, an FPGA wrapper, or an on-chip debug bridge.

Parameters:
- SAMPLE_DELAY, 0: extra register stages between the core's shift-out pin and dbg_shift_out (pad/sync flops); shifts the capture window later by this many cycles.
- TIMEOUT_W, 16: width of the WAIT timeout counter (used only with the optional feature).

Ports:
- clk  in  1  clock, shared with the core.
- rst  in  1  synchronous reset, active-high.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high only in IDLE.
- cmd_op  in  3  0=LOAD, 1=DUMP, 2=RUN, 3=STEP, 4=WAIT; 5-7 reserved.
- cmd_reg  in  2  register select: 0=PC, 1=SP, 2=EXEC, 3=STACK_TOP.
- cmd_data  in  8  byte for LOAD.
- rsp_valid  out  1  one-cycle completion pulse.
- rsp_data  out  8  DUMP byte; WAIT status; 0 otherwise.
- dbg_run  out  1  to core run pin.
- dbg_step  out  1  to core step pin.
- dbg_load  out  1  to core load pin.
- dbg_dump  out  1  to core dump pin.
- dbg_shift_in  out  1  to core shift-in pin.
- dbg_reg_sel  out  2  to core register-select pins.
- dbg_shift_out  in  1  from core shift-out pin.
- tgt_stop  in  1  core stop flag (stop or sleep).
- tgt_sleep  in  1  core sleep flag.

Behaviour:
- Reset: state IDLE, all outputs 0 (cmd_ready=1 after reset deasserts). Reset mid-operation aborts immediately. A partial shift is harmless because the core acts only on load/dump.
- Handshake: a command is accepted on a cycle with cmd_valid and cmd_ready both high. cmd_op, cmd_reg and cmd_data are latched at acceptance.
- Once accepted, dbg_reg_sel holds the latched register select until RESP. In IDLE it holds its last value.
- Cycle numbering: cycle 0 is the cycle after acceptance.
- LOAD:
  - dbg_shift_in carries cmd_data MSB-first: bit 7-k in cycle k, k=0..7.
  - Cycle 8: dbg_load=1 and dbg_shift_in=0.
  - Cycle 9: RESP, rsp_valid=1, rsp_data=0.
- DUMP:
  - Cycle 0: dbg_dump=1.
  - Byte bit 7-j is captured at the end of cycle 2+SAMPLE_DELAY+j, j=0..7, MSB-first into a shift register.
  - The cycle after the last capture: rsp_valid=1, rsp_data=byte.
  - dbg_shift_in is held at 0 throughout.
- RUN/STEP:
  - Cycle 0: dbg_run=1, dbg_step = (op==STEP).
  - Cycle 1: both 0. This guarantees a rising edge on the next command, since the core detects run edges.
  - Cycle 2: RESP, rsp_data=0.
  - If the core is not stopped or sleeping, the core ignores the run; the host does not check this.
- WAIT: stays in WAIT until tgt_stop is sampled high, then RESP with rsp_data={6'b0, tgt_sleep, timeout_flag}. timeout_flag is 0 without the optional feature.
- Reserved ops: RESP next cycle with rsp_data=8'hFF; no pins toggle.
- FSM states: IDLE, SHIFT, STROBE, DUMP, CAPTURE, RUN, WAIT, RESP. RESP always returns to IDLE, so there is at least one idle cycle between commands.
- Bit counter: 3-bit, with wrap detected at 7. The CAPTURE delay counter is sized to cover SAMPLE_DELAY+1.
- At most one of dbg_load, dbg_dump, dbg_run is ever high in a cycle. Each is high for exactly one cycle per command.

Optional Feature:
- Macro: SPELL_DBG_TIMEOUT_EN.
- Defined: WAIT loads a TIMEOUT_W-bit counter with all ones on entry. If the counter reaches 0 before tgt_stop is seen, the host goes to RESP with timeout_flag=1.
- Undefined: WAIT is unbounded, timeout_flag is tied to 0, and the counter is absent.

Decomposition:
- Package spell_dbg_pkg: op-code constants (OP_LOAD..OP_WAIT), register-select constants matching the core's 0..3 mapping, FSM state enum.
- Sub-module spell_dbg_shifter: 8-bit bidirectional serialiser/deserialiser with load, shift-out MSB, shift-in capture and 3-bit bit counter with a done flag.

Test Plan:
- LOAD reg=PC data=8'hA5 against the core model -> dbg_shift_in sequence 1,0,1,0,0,1,0,1 over cycles 0-7; dbg_load high in cycle 8 only; core PC=8'hA5; rsp_valid in cycle 9.
- LOAD SP 8'h1F, then DUMP SP -> rsp_data=8'h1F; repeat with SAMPLE_DELAY=2 and a 2-flop delay on dbg_shift_out -> same result.
- LOAD STACK_TOP 8'h3C, then DUMP STACK_TOP -> rsp_data=8'h3C; core SP incremented by 1.
- STEP issued twice back-to-back with the core in sleep -> dbg_run pulses separated by at least 2 low cycles; core executes two instructions; WAIT returns rsp_data[1]=0 once the core stops.
- rst asserted in cycle 4 of a LOAD -> next cycle all dbg_* outputs are 0 and cmd_ready=1; core PC unchanged.
- With SPELL_DBG_TIMEOUT_EN, TIMEOUT_W=4, tgt_stop held 0 -> rsp_valid after 16 WAIT cycles with rsp_data=8'h01. Without the macro -> no response while tgt_stop=0.

Source files
------------

// File: rtl/spell_dbg_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spell_dbg_pkg
//  Description : Shared constants for the spell debug-port host: command
//                op-codes, core register selects and the host FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package spell_dbg_pkg;

  // Command op-codes presented on cmd_op; 5..7 are reserved
  localparam logic [2:0] OP_LOAD = 3'd0;
  localparam logic [2:0] OP_DUMP = 3'd1;
  localparam logic [2:0] OP_RUN  = 3'd2;
  localparam logic [2:0] OP_STEP = 3'd3;
  localparam logic [2:0] OP_WAIT = 3'd4;

  // Register selects, identical to the core's own 0..3 mapping
  localparam logic [1:0] REG_PC        = 2'd0;
  localparam logic [1:0] REG_SP        = 2'd1;
  localparam logic [1:0] REG_EXEC      = 2'd2;
  localparam logic [1:0] REG_STACK_TOP = 2'd3;

  // Response byte returned for a reserved op-code
  localparam logic [7:0] RSP_RESERVED = 8'hFF;

  // Host sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_STROBE  = 3'd2,
    ST_DUMP    = 3'd3,
    ST_CAPTURE = 3'd4,
    ST_RUN     = 3'd5,
    ST_WAIT    = 3'd6,
    ST_RESP    = 3'd7
  } state_t;

endpackage : spell_dbg_pkg
`default_nettype wire

// File: rtl/spell_dbg_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : spell_dbg_shifter
//  Description : 8-bit serialiser/deserialiser for the debug port. A parallel
//                load clears the bit counter; every shift moves the byte one
//                place towards the MSB and inserts ser_in at the LSB, so the
//                same register drives LOAD data out MSB-first and assembles
//                DUMP data MSB-first. done flags the eighth bit position.
//  Revision    : 1.0 - initial release
// ============================================================================
module spell_dbg_shifter (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       shift,
  input  logic       ser_in,
  output logic [7:0] data,
  output logic       done
);

  logic [2:0] bit_cnt;

  // Parallel load takes priority over shifting; counter tracks bit position
  always_ff @(posedge clk) begin
    if (rst) begin
      data    <= 8'h00;
      bit_cnt <= 3'd0;
    end else if (load) begin
      data    <= load_data;
      bit_cnt <= 3'd0;
    end else if (shift) begin
      data    <= {data[6:0], ser_in};
      bit_cnt <= bit_cnt + 3'd1;
    end
  end

  // The eighth bit is in flight when the counter sits at its wrap value
  assign done = (bit_cnt == 3'd7);

endmodule : spell_dbg_shifter
`default_nettype wire

// File: rtl/spell_dbg_host.sv
`default_nettype none
// ============================================================================
//  Module      : spell_dbg_host
//  Description : Host-side initiator for the spell core serial debug port.
//                Takes LOAD / DUMP / RUN / STEP / WAIT commands on a
//                valid/ready interface and turns each one into the pin
//                sequence the core's 8-bit debug shift register expects.
//                DUMP results and WAIT status come back as single-cycle
//                responses on rsp_valid / rsp_data.
//  Options     : SPELL_DBG_TIMEOUT_EN - bounds WAIT with a TIMEOUT_W-bit
//                down-counter; when it expires the response carries
//                timeout_flag (rsp_data[0]) set.
//  Revision    : 1.0 - initial release
// ============================================================================
module spell_dbg_host
  import spell_dbg_pkg::*;
#(
  parameter int SAMPLE_DELAY = 0,
  parameter int TIMEOUT_W    = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [1:0] cmd_reg,
  input  logic [7:0] cmd_data,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       dbg_run,
  output logic       dbg_step,
  output logic       dbg_load,
  output logic       dbg_dump,
  output logic       dbg_shift_in,
  output logic [1:0] dbg_reg_sel,
  input  logic       dbg_shift_out,
  input  logic       tgt_stop,
  input  logic       tgt_sleep
);

  // The capture delay counter has to reach SAMPLE_DELAY+1
  localparam int DLY_W = $clog2(SAMPLE_DELAY + 2);
  localparam logic [DLY_W-1:0] DLY_LAST = DLY_W'(SAMPLE_DELAY + 1);

  state_t           state;
  logic [DLY_W-1:0] dly_cnt;
  logic             shift_en;
  logic             capture_now;

  logic             sh_load;
  logic [7:0]       sh_load_data;
  logic             sh_shift;
  logic             sh_ser;
  logic [7:0]       sh_data;
  logic             sh_done;

`ifdef SPELL_DBG_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] tmo_cnt;
`else
  // Without the counter the timeout can never fire
  localparam logic TIMEOUT_FLAG = (TIMEOUT_W < 0);
`endif

  // Only IDLE accepts a command, which forces a gap between commands
  assign cmd_ready = (state == ST_IDLE);

  // The shift-in pin follows the shifter MSB only while LOAD data is
  // streaming; at every other time (DUMP included) it is held low
  assign dbg_shift_in = shift_en & sh_data[7];

  // The first DUMP bit arrives SAMPLE_DELAY+1 cycles into CAPTURE
  assign capture_now = (state == ST_CAPTURE) && (dly_cnt == DLY_LAST);

  // Shifter control: load on acceptance, shift out during SHIFT, shift in
  // the core's serial output during the capture window
  always_comb begin
    sh_load      = 1'b0;
    sh_load_data = 8'h00;
    sh_shift     = 1'b0;
    sh_ser       = 1'b0;
    if ((state == ST_IDLE) && cmd_valid) begin
      sh_load      = 1'b1;
      sh_load_data = (cmd_op == OP_LOAD) ? cmd_data : 8'h00;
    end
    if (state == ST_SHIFT) begin
      sh_shift = 1'b1;
    end
    if (capture_now) begin
      sh_shift = 1'b1;
      sh_ser   = dbg_shift_out;
    end
  end

  spell_dbg_shifter u_shifter (
    .clk       (clk),
    .rst       (rst),
    .load      (sh_load),
    .load_data (sh_load_data),
    .shift     (sh_shift),
    .ser_in    (sh_ser),
    .data      (sh_data),
    .done      (sh_done)
  );

  // Command sequencer with registered pin and response outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      dly_cnt     <= '0;
      shift_en    <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'h00;
      dbg_run     <= 1'b0;
      dbg_step    <= 1'b0;
      dbg_load    <= 1'b0;
      dbg_dump    <= 1'b0;
      dbg_reg_sel <= REG_PC;
`ifdef SPELL_DBG_TIMEOUT_EN
      tmo_cnt     <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            dbg_reg_sel <= cmd_reg;
            case (cmd_op)
              OP_LOAD: begin
                shift_en <= 1'b1;
                state    <= ST_SHIFT;
              end
              OP_DUMP: begin
                dbg_dump <= 1'b1;
                state    <= ST_DUMP;
              end
              OP_RUN, OP_STEP: begin
                dbg_run  <= 1'b1;
                dbg_step <= (cmd_op == OP_STEP);
                state    <= ST_RUN;
              end
              OP_WAIT: begin
`ifdef SPELL_DBG_TIMEOUT_EN
                tmo_cnt <= '1;
`endif
                state   <= ST_WAIT;
              end
              default: begin
                rsp_valid <= 1'b1;
                rsp_data  <= RSP_RESERVED;
                state     <= ST_RESP;
              end
            endcase
          end
        end

        // Eight data bits leave MSB-first; the last one is followed by the
        // load strobe with the data pin already returned low
        ST_SHIFT: begin
          if (sh_done) begin
            shift_en <= 1'b0;
            dbg_load <= 1'b1;
            state    <= ST_STROBE;
          end
        end

        // Shared settle cycle: ends the LOAD strobe, and gives RUN/STEP a
        // low cycle so the next run command always presents a fresh edge
        ST_STROBE: begin
          dbg_load  <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_data  <= 8'h00;
          state     <= ST_RESP;
        end

        ST_DUMP: begin
          dbg_dump <= 1'b0;
          dly_cnt  <= '0;
          state    <= ST_CAPTURE;
        end

        // Wait out the core and pad latency, then take eight bits
        ST_CAPTURE: begin
          if (!capture_now) begin
            dly_cnt <= dly_cnt + DLY_W'(1);
          end else if (sh_done) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {sh_data[6:0], dbg_shift_out};
            state     <= ST_RESP;
          end
        end

        ST_RUN: begin
          dbg_run  <= 1'b0;
          dbg_step <= 1'b0;
          state    <= ST_STROBE;
        end

        ST_WAIT: begin
          if (tgt_stop) begin
            rsp_valid <= 1'b1;
`ifdef SPELL_DBG_TIMEOUT_EN
            rsp_data  <= {6'b0, tgt_sleep, 1'b0};
`else
            rsp_data  <= {6'b0, tgt_sleep, TIMEOUT_FLAG};
`endif
            state     <= ST_RESP;
          end
`ifdef SPELL_DBG_TIMEOUT_EN
          else if (tmo_cnt == '0) begin
            rsp_valid <= 1'b1;
            rsp_data  <= {6'b0, tgt_sleep, 1'b1};
            state     <= ST_RESP;
          end else begin
            tmo_cnt <= tmo_cnt - TIMEOUT_W'(1);
          end
`endif
        end

        ST_RESP: begin
          rsp_valid <= 1'b0;
          rsp_data  <= 8'h00;
          state     <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule : spell_dbg_host
`default_nettype wire

// File: tb/tb_spell_dbg_host.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spell_dbg_host
//  Description : Self-checking bench for spell_dbg_host. A pin-level model of
//                the core's debug register file sits on the dbg_* pins, a
//                transaction-level model predicts every response, and a
//                monitor compares responses from a scoreboard queue.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spell_dbg_host;
  import spell_dbg_pkg::*;

  localparam int SD = 2;
`ifdef SPELL_DBG_TIMEOUT_EN
  localparam int TW = 4;
`else
  localparam int TW = 16;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic [1:0] cmd_reg = 2'd0;
  logic [7:0] cmd_data = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in;
  logic [1:0] dbg_reg_sel;
  logic       dbg_shift_out;
  logic       tgt_stop = 1'b1;
  logic       tgt_sleep = 1'b0;

  int n_checks = 0;
  int n_err = 0;
  int cyc = 0;

  spell_dbg_host #(.SAMPLE_DELAY(SD), .TIMEOUT_W(TW)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_reg(cmd_reg), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .dbg_run(dbg_run), .dbg_step(dbg_step), .dbg_load(dbg_load),
    .dbg_dump(dbg_dump), .dbg_shift_in(dbg_shift_in),
    .dbg_reg_sel(dbg_reg_sel), .dbg_shift_out(dbg_shift_out),
    .tgt_stop(tgt_stop), .tgt_sleep(tgt_sleep)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- pin-level core model ----------------
  logic [7:0]    c_pc = 8'h00, c_sp = 8'h80, c_ex = 8'h00, c_sr = 8'h00;
  logic [7:0]    c_mem [0:255];
  logic          c_so = 1'b0;
  logic [SD-1:0] c_pipe = '0;
  logic          c_run_q = 1'b0;
  int            c_runs = 0, c_steps = 0;

  initial foreach (c_mem[i]) c_mem[i] = 8'h00;

  function automatic logic [7:0] c_read(input logic [1:0] r);
    case (r)
      2'd0:    return c_pc;
      2'd1:    return c_sp;
      2'd2:    return c_ex;
      default: return c_mem[c_sp];
    endcase
  endfunction

  // Core: load commits the shift register, dump reloads it (STACK_TOP pops)
  always @(posedge clk) begin
    if (dbg_load) begin
      case (dbg_reg_sel)
        2'd0:    c_pc <= c_sr;
        2'd1:    c_sp <= c_sr;
        2'd2:    c_ex <= c_sr;
        default: c_mem[c_sp] <= c_sr;
      endcase
    end
    if (dbg_dump) begin
      c_sr <= c_read(dbg_reg_sel);
      if (dbg_reg_sel == 2'd3) c_sp <= c_sp + 8'd1;
    end else begin
      c_sr <= {c_sr[6:0], dbg_shift_in};
    end
    c_so   <= c_sr[7];
    c_pipe <= {c_pipe[SD-2:0], c_so};
    c_run_q <= dbg_run;
    if (dbg_run && !c_run_q) begin
      c_runs <= c_runs + 1;
      if (dbg_step) c_steps <= c_steps + 1;
    end
  end
  assign dbg_shift_out = c_pipe[SD-1];

  // ---------------- transaction-level reference ----------------
  logic [7:0] m_reg [0:2];
  logic [7:0] m_mem [0:255];
  initial begin
    m_reg[0] = 8'h00; m_reg[1] = 8'h80; m_reg[2] = 8'h00;
    foreach (m_mem[i]) m_mem[i] = 8'h00;
  end

  task automatic predict(input logic [2:0] op, input logic [1:0] r, input logic [7:0] d,
                         output logic [7:0] e, output int lat);
    e = 8'h00;
    case (op)
      OP_LOAD: begin
        if (r == REG_STACK_TOP) m_mem[m_reg[1]] = d; else m_reg[r] = d;
        lat = 9;
      end
      OP_DUMP: begin
        if (r == REG_STACK_TOP) begin
          e = m_mem[m_reg[1]];
          m_reg[1] = m_reg[1] + 8'd1;
        end else begin
          e = m_reg[r];
        end
        lat = 10 + SD;
      end
      OP_RUN, OP_STEP: lat = 2;
      default: begin e = 8'hFF; lat = 0; end
    endcase
  endtask

  // ---------------- scoreboard ----------------
  typedef struct { logic [7:0] data; int lat; int acc; } exp_t;
  exp_t exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Response monitor
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("rsp_data", 32'(rsp_data), 32'(e.data));
        if (e.lat >= 0) chk("rsp_latency", 32'(cyc - e.acc - 1), 32'(e.lat));
      end
    end
  end

  // Pin monitor: strobes mutually exclusive, run pulses one cycle with a gap
  int last_run = -100;
  always @(negedge clk) begin
    if (!rst) begin
      if (dbg_load || dbg_dump || dbg_run)
        chk("strobe_onehot", 32'(dbg_load) + 32'(dbg_dump) + 32'(dbg_run), 32'd1);
      if (dbg_step) chk("step_with_run", 32'(dbg_run), 32'd1);
      if (dbg_run) begin
        chk("run_gap", 32'(cyc - last_run >= 3), 32'd1);
        last_run = cyc;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic issue(input logic [2:0] op, input logic [1:0] r, input logic [7:0] d,
                       input logic [7:0] e, input int lat);
    int guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1; cmd_op = op; cmd_reg = r; cmd_data = d;
    exp_q.push_back('{data: e, lat: lat, acc: cyc});
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [2:0] op, input logic [1:0] r, input logic [7:0] d);
    logic [7:0] e;
    int lat;
    predict(op, r, d, e, lat);
    issue(op, r, d, e, lat);
  endtask

  task automatic do_wait(input logic sleep, input int delay);
    tgt_stop = 1'b0; tgt_sleep = 1'b0;
    issue(OP_WAIT, REG_PC, 8'h00, {6'b0, sleep, 1'b0}, -1);
    repeat (delay) @(negedge clk);
    tgt_sleep = sleep; tgt_stop = 1'b1;
  endtask

  task automatic wait_drain(input int max);
    int g = 0;
    while (exp_q.size() != 0 && g < max) begin
      @(negedge clk);
      g++;
    end
    chk("drain", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  // Watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] pat;
    logic [7:0] sp_before;
    int runs0, steps0;

    // Reset state
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp", {23'b0, rsp_valid, rsp_data}, 32'd0);
    chk("rst_pins", {25'b0, dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in, dbg_reg_sel}, 32'd0);

    // LOAD PC A5 with pin-sequence check
    pat = 8'hA5;
    do_cmd(OP_LOAD, REG_PC, pat);
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("load_bit%0d", k), 32'(dbg_shift_in), 32'(pat[7-k]));
      chk("load_low_early", 32'(dbg_load), 32'd0);
      @(negedge clk);
    end
    chk("load_strobe", {30'b0, dbg_load, dbg_shift_in}, 32'd2);
    wait_drain(50);
    chk("core_pc", 32'(c_pc), 32'hA5);

    // LOAD SP / DUMP SP
    do_cmd(OP_LOAD, REG_SP, 8'h1F);
    do_cmd(OP_DUMP, REG_SP, 8'h00);
    wait_drain(50);

    // LOAD STACK_TOP / DUMP STACK_TOP pops
    do_cmd(OP_LOAD, REG_STACK_TOP, 8'h3C);
    wait_drain(50);
    sp_before = c_sp;
    do_cmd(OP_DUMP, REG_STACK_TOP, 8'h00);
    wait_drain(50);
    chk("core_sp_pop", 32'(c_sp), 32'(sp_before + 8'd1));

    // Two STEPs with the core asleep, then WAIT for stop
    tgt_stop = 1'b1; tgt_sleep = 1'b1;
    runs0 = c_runs; steps0 = c_steps;
    do_cmd(OP_STEP, REG_PC, 8'h00);
    do_cmd(OP_STEP, REG_PC, 8'h00);
    wait_drain(50);
    chk("step_runs", 32'(c_runs - runs0), 32'd2);
    chk("step_steps", 32'(c_steps - steps0), 32'd2);
    do_wait(1'b0, 3);
    wait_drain(50);

    // Reset in cycle 4 of a LOAD aborts it
    issue(OP_LOAD, REG_PC, 8'h5A, 8'h00, 9);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort_pins", {25'b0, dbg_run, dbg_step, dbg_load, dbg_dump, dbg_shift_in, dbg_reg_sel}, 32'd0);
    chk("abort_ready", 32'(cmd_ready), 32'd1);
    rst = 1'b0;
    exp_q.delete();
    repeat (12) @(negedge clk);
    chk("abort_core_pc", 32'(c_pc), 32'hA5);

    // WAIT with the core never stopping
`ifdef SPELL_DBG_TIMEOUT_EN
    tgt_stop = 1'b0; tgt_sleep = 1'b0;
    issue(OP_WAIT, REG_PC, 8'h00, 8'h01, 16);
    repeat (24) @(negedge clk);
    chk("wait_timeout_done", 32'(exp_q.size()), 32'd0);
    tgt_stop = 1'b1;
`else
    tgt_stop = 1'b0; tgt_sleep = 1'b0;
    issue(OP_WAIT, REG_PC, 8'h00, 8'h00, -1);
    repeat (40) @(negedge clk);
    chk("wait_unbounded", 32'(exp_q.size()), 32'd1);
    tgt_stop = 1'b1;
`endif
    wait_drain(50);

    // Randomised command mix against the reference
    for (int i = 0; i < 80; i++) begin
      int roll;
      logic [1:0] r;
      logic [7:0] d;
      roll = $urandom_range(0, 19);
      r = 2'($urandom_range(0, 3));
      d = 8'($urandom_range(0, 255));
      if (roll < 6)       do_cmd(OP_LOAD, r, d);
      else if (roll < 12) do_cmd(OP_DUMP, r, d);
      else if (roll < 14) do_cmd(OP_RUN, r, d);
      else if (roll < 16) do_cmd(OP_STEP, r, d);
      else if (roll < 18) do_wait(1'($urandom_range(0, 1)), $urandom_range(0, 5));
      else                do_cmd(3'(5 + $urandom_range(0, 2)), r, d);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    wait_drain(300);
    chk("final_core_pc", 32'(c_pc), 32'(m_reg[0]));
    chk("final_core_sp", 32'(c_sp), 32'(m_reg[1]));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_spell_dbg_host
`default_nettype wire
